// File: rtl/draw_pkg.sv
// Shared definitions for the drawing engines and the framebuffer arbiter.
package draw_pkg;

   localparam int DRAW_COORD_W  = 10;
   localparam int DRAW_COLOUR_W = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_e;

endpackage

// File: rtl/draw_arbiter_rr_pick.sv
// Round-robin winner selection: first requester at or after ptr, wrapping.
module rr_pick #(
   parameter int N_REQ = 3,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N_REQ-1:0] win_o,
   output logic [PTR_W-1:0] idx_o
);

   always_comb begin
      int   j;
      logic found;
      win_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         j = int'(ptr_i) + i;
         if (j >= N_REQ) j = j - N_REQ;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            win_o[j] = 1'b1;
            idx_o    = PTR_W'(j);
         end
      end
   end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin owner of the single VGA framebuffer write port.
module draw_arbiter
   import draw_pkg::*;
#(
   parameter int N_REQ    = 3,
   parameter int COORD_W  = DRAW_COORD_W,
   parameter int COLOUR_W = DRAW_COLOUR_W,
   parameter int MAX_HOLD = 1024
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      enable,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          done,
   input  logic [N_REQ-1:0]          wren_in,
   input  logic [N_REQ*COORD_W-1:0]  x_in,
   input  logic [N_REQ*COORD_W-1:0]  y_in,
   input  logic [N_REQ*COLOUR_W-1:0] colour_in,
   output logic [N_REQ-1:0]          grant,
   output logic [COORD_W-1:0]        x,
   output logic [COORD_W-1:0]        y,
   output logic [COLOUR_W-1:0]       colour,
   output logic                      writeEn,
   output logic                      busy,
   output logic                      timeout
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_REQ - 1);

   state_e           state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] gidx_q, gidx_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic             timeout_q, timeout_d;
   logic [N_REQ-1:0] pick_win;
   logic [PTR_W-1:0] pick_idx;
   logic             g_done, g_req, at_limit;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req_i (req),
      .ptr_i (ptr_q),
      .win_o (pick_win),
      .idx_o (pick_idx)
   );

   assign g_done   = done[gidx_q];
   assign g_req    = req[gidx_q];
   assign at_limit = (hold_q == HOLD_LAST);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gidx_d    = gidx_q;
      hold_d    = hold_q;
      grant_d   = grant_q;
      timeout_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (|req) begin
               grant_d = pick_win;
               gidx_d  = pick_idx;
               hold_d  = '0;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (g_done || !g_req || at_limit) begin
               grant_d   = '0;
               hold_d    = '0;
               ptr_d     = (gidx_q == PTR_LAST) ? '0 : gidx_q + 1'b1;
               // limit only counts as a timeout when nothing else released
               timeout_d = !g_done && g_req;
               state_d   = S_GAP;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         gidx_q    <= '0;
         hold_q    <= '0;
         grant_q   <= '0;
         timeout_q <= 1'b0;
      end else if (enable) begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gidx_q    <= gidx_d;
         hold_q    <= hold_d;
         grant_q   <= grant_d;
         timeout_q <= timeout_d;
      end else begin
         timeout_q <= 1'b0;
      end
   end

   always_comb begin
      x      = '0;
      y      = '0;
      colour = '0;
      if (|grant_q) begin
         x      = x_in[gidx_q*COORD_W +: COORD_W];
         y      = y_in[gidx_q*COORD_W +: COORD_W];
         colour = colour_in[gidx_q*COLOUR_W +: COLOUR_W];
      end
   end

   assign grant   = grant_q;
   assign writeEn = enable & |(grant_q & wren_in);
   assign busy    = (state_q == S_GRANT) || (state_q == S_GAP);
   assign timeout = timeout_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter with N_REQ=3 and MAX_HOLD=8.
module tb_draw_arbiter;

   logic        clk = 1'b0;
   logic        resetn, enable;
   logic [2:0]  req, done, wren_in;
   logic [29:0] x_in, y_in;
   logic [8:0]  colour_in;
   logic [2:0]  grant;
   logic [9:0]  x, y;
   logic [2:0]  colour;
   logic        writeEn, busy, timeout;

   int total = 0;
   int bad   = 0;

   logic [2:0] exp_g [13] = '{3'b001, 3'b001, 3'b000, 3'b000,
                              3'b010, 3'b010, 3'b000, 3'b000,
                              3'b100, 3'b100, 3'b000, 3'b000,
                              3'b001};
   logic [2:0] drv_d [13] = '{3'b000, 3'b001, 3'b000, 3'b000,
                              3'b000, 3'b010, 3'b000, 3'b000,
                              3'b000, 3'b100, 3'b000, 3'b000,
                              3'b000};
   logic       exp_b [13] = '{1'b1, 1'b1, 1'b1, 1'b0,
                              1'b1, 1'b1, 1'b1, 1'b0,
                              1'b1, 1'b1, 1'b1, 1'b0,
                              1'b1};

   draw_arbiter #(
      .N_REQ    (3),
      .COORD_W  (10),
      .COLOUR_W (3),
      .MAX_HOLD (8)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .enable    (enable),
      .req       (req),
      .done      (done),
      .wren_in   (wren_in),
      .x_in      (x_in),
      .y_in      (y_in),
      .colour_in (colour_in),
      .grant     (grant),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .writeEn   (writeEn),
      .busy      (busy),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      resetn    = 1'b0;
      enable    = 1'b1;
      req       = '0;
      done      = '0;
      wren_in   = '0;
      x_in      = '0;
      y_in      = '0;
      colour_in = '0;
      tick();
      tick();
      resetn = 1'b1;
      #1;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_timeout", 32'(timeout), 0);
      chk("rst_wen", 32'(writeEn), 0);

      // idle: strobes without a grant must not reach the adapter
      wren_in   = 3'b111;
      x_in      = {10'd7, 10'd6, 10'd5};
      y_in      = {10'd9, 10'd8, 10'd4};
      colour_in = 9'b111_101_011;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_grant", 32'(grant), 0);
         chk("idle_wen", 32'(writeEn), 0);
         chk("idle_xyc", {x, y, colour}, 0);
         chk("idle_busy", 32'(busy), 0);
      end
      wren_in = '0;

      // all requesting, release on 2nd granted cycle
      req = 3'b111;
      tick();
      for (int i = 0; i < 13; i++) begin
         done = drv_d[i];
         #1;
         chk($sformatf("rr_grant[%0d]", i), 32'(grant), 32'(exp_g[i]));
         chk($sformatf("rr_busy[%0d]", i), 32'(busy), 32'(exp_b[i]));
         tick();
      end
      req  = '0;
      done = '0;
      tick();
      tick();

      // requester 1 streams 5 pixels; requester 0 writes are dropped
      req = 3'b010;
      tick();
      for (int p = 0; p < 5; p++) begin
         wren_in         = 3'b011;
         x_in            = '0;
         y_in            = '0;
         colour_in       = '0;
         x_in[9:0]       = 10'd999;
         y_in[9:0]       = 10'd5;
         colour_in[2:0]  = 3'b011;
         x_in[19:10]     = 10'(10 + p);
         y_in[19:10]     = 10'd64;
         colour_in[5:3]  = 3'b100;
         if (p == 4) begin
            done = 3'b010;
            req  = 3'b000;
         end
         #1;
         chk("pix_grant", 32'(grant), 32'b010);
         chk("pix_wen", 32'(writeEn), 1);
         chk("pix_x", 32'(x), 32'(10 + p));
         chk("pix_y", 32'(y), 64);
         chk("pix_colour", 32'(colour), 32'b100);
         tick();
      end
      done = '0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("pix_after_wen", 32'(writeEn), 0);
         chk("pix_after_x", 32'(x), 0);
         tick();
      end
      wren_in = '0;

      // requester 2 holds without done: forced release after 8 cycles
      req = 3'b100;
      tick();
      for (int i = 0; i < 8; i++) begin
         chk("to_grant", 32'(grant), 32'b100);
         chk("to_early", 32'(timeout), 0);
         tick();
      end
      req = 3'b111;
      #1;
      chk("to_pulse", 32'(timeout), 1);
      chk("to_gap_grant", 32'(grant), 0);
      chk("to_gap_busy", 32'(busy), 1);
      tick();
      chk("to_pulse_end", 32'(timeout), 0);
      chk("to_idle_grant", 32'(grant), 0);
      tick();
      chk("to_ptr_wrap", 32'(grant), 32'b001);
      done = 3'b001;
      tick();
      done = '0;
      req  = '0;
      tick();

      // done on the limit cycle is a normal release
      req = 3'b100;
      tick();
      for (int i = 0; i < 8; i++) begin
         done = (i == 7) ? 3'b100 : 3'b000;
         #1;
         chk("lim_grant", 32'(grant), 32'b100);
         tick();
      end
      done = '0;
      req  = '0;
      chk("lim_no_timeout", 32'(timeout), 0);
      chk("lim_released", 32'(grant), 0);
      tick();
      chk("lim_no_timeout2", 32'(timeout), 0);

      // advance ptr to 1, then reset in 3rd cycle of requester 2 grant
      req = 3'b001;
      tick();
      done = 3'b001;
      tick();
      done = '0;
      req  = 3'b100;
      tick();
      tick();
      chk("rstg_grant", 32'(grant), 32'b100);
      tick();
      tick();
      resetn  = 1'b0;
      wren_in = 3'b100;
      #1;
      chk("rstg_wen_before", 32'(writeEn), 1);
      tick();
      chk("rstg_grant_clr", 32'(grant), 0);
      chk("rstg_wen_clr", 32'(writeEn), 0);
      chk("rstg_busy_clr", 32'(busy), 0);
      resetn  = 1'b1;
      wren_in = '0;
      req     = 3'b111;
      tick();
      chk("rstg_first_r0", 32'(grant), 32'b001);
      done = 3'b001;
      req  = '0;
      tick();
      done = '0;
      tick();

      // 4-cycle enable stall delays the timeout by 4 cycles
      req = 3'b010;
      tick();
      for (int i = 0; i < 12; i++) begin
         enable  = (i >= 2 && i < 6) ? 1'b0 : 1'b1;
         wren_in = 3'b010;
         #1;
         chk("stall_grant", 32'(grant), 32'b010);
         chk("stall_wen", 32'(writeEn), 32'(enable));
         chk("stall_no_to", 32'(timeout), 0);
         tick();
      end
      req     = '0;
      wren_in = '0;
      enable  = 1'b1;
      #1;
      chk("stall_released", 32'(grant), 0);
      chk("stall_timeout", 32'(timeout), 1);
      tick();
      chk("stall_to_end", 32'(timeout), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
